aes_key_expand_stage: RTL and testbench

Parametrised successor to the first AES-GCM pipeline stage. It expands AES-128 or AES-256 cipher keys iteratively, one round key per cycle, instead of through a single combinational expansion. A valid/ready handshake and sideband buffering carry the plaintext, AAD, IV, size and flag fields alongside the key. An optional key cache skips re-expansion when consecutive beats of one instance reuse the same key.

---
 rtl/aes_key_expand_stage.sv | 180 ++++++++++++++++++
 tb/tb_aes_key_expand_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand_stage.sv
// AES-128/256 key expansion stage: iterative round-key generation (4 words per
// cycle) with valid/ready handshake, sideband capture and an optional
// schedule cache reused across beats of the same instance.
module aes_key_expand_stage #(
    parameter int SB_W         = 481,
    parameter bit ENABLE_CACHE = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [0:255]    i_cipher_key,
    input  logic            i_key_256,
    input  logic            i_new_instance,
    input  logic [SB_W-1:0] i_sideband,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [0:1919]   o_key_schedule,
    output logic [3:0]      o_num_rounds,
    output logic [SB_W-1:0] o_sideband,
    output logic            o_new_instance,
    output logic            o_cache_hit
);
    typedef enum logic [1:0] {IDLE, EXPAND, HOLD} state_t;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box: multiplicative inverse (x^254) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        x252 = gmul(x240, x12);
        inv  = gmul(x252, x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t          r_state;
    logic [0:1919]   r_sched;
    logic            r_256;          // mode of the schedule held in r_sched
    logic            r_cache_valid;
    logic [5:0]      r_widx;         // first word index produced this cycle
    logic            r_valid;
    logic [3:0]      r_num_rounds;
    logic [SB_W-1:0] r_sideband;
    logic            r_new_instance;
    logic            r_cache_hit;

    logic            w_accept, w_hit, w_rot_step, w_last;
    logic [10:0]     w_base, w_nk_bits;
    logic [31:0]     w_prev, w_rot, w_sub_rot, w_sub, w_t;
    logic [31:0]     w_n0, w_n1, w_n2, w_n3;
    logic [127:0]    w_old;
    logic [3:0]      w_rcon_idx;

    assign o_ready  = (r_state == IDLE) | ((r_state == HOLD) & i_ready);
    assign w_accept = i_valid & o_ready;
    // Key is not compared: one key per instance is guaranteed upstream
    assign w_hit    = ENABLE_CACHE & r_cache_valid & ~i_new_instance & (i_key_256 == r_256);

    // Word i-1 feeds the non-linear step; words i-Nk..i-Nk+3 feed the xor chain
    assign w_base     = {r_widx, 5'b0};
    assign w_nk_bits  = r_256 ? 11'd256 : 11'd128;
    assign w_prev     = r_sched[(w_base - 11'd32) +: 32];
    assign w_old      = r_sched[(w_base - w_nk_bits) +: 128];
    assign w_rot      = {w_prev[23:0], w_prev[31:24]};

    // Eight S-box instances: rotated path and plain SubWord path for AES-256
    for (genvar g = 0; g < 4; g++) begin : g_sbox
        assign w_sub_rot[g*8 +: 8] = sbox(w_rot[g*8 +: 8]);
        assign w_sub[g*8 +: 8]     = sbox(w_prev[g*8 +: 8]);
    end

    assign w_rot_step = r_256 ? ~r_widx[2] : 1'b1;
    assign w_rcon_idx = r_256 ? {1'b0, r_widx[5:3]} : r_widx[5:2];
    assign w_t        = w_rot_step ? (w_sub_rot ^ {rcon(w_rcon_idx), 24'h0}) : w_sub;
    assign w_n0       = w_old[127:96] ^ w_t;
    assign w_n1       = w_old[95:64]  ^ w_n0;
    assign w_n2       = w_old[63:32]  ^ w_n1;
    assign w_n3       = w_old[31:0]   ^ w_n2;
    assign w_last     = r_256 ? (r_widx == 6'd56) : (r_widx == 6'd40);

    // Handshake/expansion FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_sched        <= '0;
            r_256          <= 1'b0;
            r_cache_valid  <= 1'b0;
            r_widx         <= '0;
            r_valid        <= 1'b0;
            r_num_rounds   <= '0;
            r_sideband     <= '0;
            r_new_instance <= 1'b0;
            r_cache_hit    <= 1'b0;
        end else if (w_accept) begin
            r_sideband     <= i_sideband;
            r_new_instance <= i_new_instance;
            r_256          <= i_key_256;
            r_num_rounds   <= i_key_256 ? 4'd14 : 4'd10;
            if (w_hit) begin
                r_state     <= HOLD;
                r_valid     <= 1'b1;
                r_cache_hit <= 1'b1;
            end else begin
                r_state       <= EXPAND;
                r_valid       <= 1'b0;
                r_cache_hit   <= 1'b0;
                r_cache_valid <= 1'b0;
                r_sched       <= i_key_256 ? {i_cipher_key, 1664'b0}
                                           : {i_cipher_key[0:127], 1792'b0};
                r_widx        <= i_key_256 ? 6'd8 : 6'd4;
            end
        end else begin
            case (r_state)
                HOLD: begin
                    if (i_ready) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                    end
                end
                EXPAND: begin
                    r_sched[w_base +: 128] <= {w_n0, w_n1, w_n2, w_n3};
                    if (w_last) begin
                        r_state       <= HOLD;
                        r_valid       <= 1'b1;
                        r_cache_valid <= 1'b1;
                        r_cache_hit   <= 1'b0;
                        r_widx        <= '0;
                    end else begin
                        r_widx <= r_widx + 6'd4;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_valid        = r_valid;
    assign o_key_schedule = r_sched;
    assign o_num_rounds   = r_num_rounds;
    assign o_sideband     = r_sideband;
    assign o_new_instance = r_new_instance;
    assign o_cache_hit    = r_cache_hit;
endmodule

// File: tb/tb_aes_key_expand_stage.sv
// Bench for aes_key_expand_stage: scoreboard of expected beats checked on each
// output handshake, plus latency, hold-stability and reset-abort checks.
module tb_aes_key_expand_stage;
    localparam int SB_W = 481;

    typedef struct {
        logic [SB_W-1:0] sb;
        logic            hit;
        logic            new_i;
        logic [3:0]      nr;
        int              lat;
        logic [127:0]    rk0;
        logic [127:0]    rk1;
        logic [127:0]    rkl;
    } exp_t;

    logic            clk, rst;
    logic            i_valid, o_ready, i_key_256, i_new_instance, i_ready;
    logic [0:255]    i_cipher_key;
    logic [SB_W-1:0] i_sideband, o_sideband;
    logic            o_valid, o_new_instance, o_cache_hit;
    logic [0:1919]   o_key_schedule;
    logic [3:0]      o_num_rounds;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t exp_q[$];
    int   acc_q[$];
    logic pv = 1'b0, ph = 1'b0;

    localparam logic [127:0] K128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK1A  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK10A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RK14B = 128'hfe4890d1e6188d0b046df344706c631e;
    logic [0:255] key128, key256;

    aes_key_expand_stage #(.SB_W(SB_W), .ENABLE_CACHE(1'b1)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_cipher_key(i_cipher_key), .i_key_256(i_key_256),
        .i_new_instance(i_new_instance), .i_sideband(i_sideband),
        .o_valid(o_valid), .i_ready(i_ready), .o_key_schedule(o_key_schedule),
        .o_num_rounds(o_num_rounds), .o_sideband(o_sideband),
        .o_new_instance(o_new_instance), .o_cache_hit(o_cache_hit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rk(input int r);
        return o_key_schedule[r*128 +: 128];
    endfunction

    function automatic logic [SB_W-1:0] mk_sb(input int seed);
        logic [511:0] t;
        for (int k = 0; k < 16; k++) t[k*32 +: 32] = $urandom ^ seed;
        return t[SB_W-1:0];
    endfunction

    function automatic exp_t mk_exp(input logic [SB_W-1:0] sb, input logic hit, input logic new_i,
                                    input logic [3:0] nr, input int lat, input logic [127:0] rk0,
                                    input logic [127:0] rk1, input logic [127:0] rkl);
        exp_t e;
        e.sb = sb; e.hit = hit; e.new_i = new_i; e.nr = nr; e.lat = lat;
        e.rk0 = rk0; e.rk1 = rk1; e.rkl = rkl;
        return e;
    endfunction

    // Scoreboard monitor: latency on first appearance, contents on handshake
    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (rst) begin
            pv = 1'b0;
            ph = 1'b0;
        end else begin
            if (o_valid && (!pv || ph)) begin
                if (acc_q.size() == 0 || exp_q.size() == 0) chk("spurious_valid", 0, 1);
                else begin
                    a = acc_q.pop_front();
                    chk("latency", 128'(cyc - a), 128'(exp_q[0].lat));
                end
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", 0, 1);
                else begin
                    e = exp_q.pop_front();
                    chk("sb_lo", o_sideband[127:0], e.sb[127:0]);
                    chk("sb_all", 128'(o_sideband == e.sb), 1);
                    chk("cache_hit", 128'(o_cache_hit), 128'(e.hit));
                    chk("new_inst", 128'(o_new_instance), 128'(e.new_i));
                    chk("num_rounds", 128'(o_num_rounds), 128'(e.nr));
                    chk("rk0", rk(0), e.rk0);
                    chk("rk1", rk(1), e.rk1);
                    chk("rk_last", rk(int'(e.nr)), e.rkl);
                    if (e.nr == 4'd10) chk("rk11_14_zero", 128'(|o_key_schedule[1408 +: 512]), 0);
                end
            end
            if (i_valid && o_ready) acc_q.push_back(cyc);
            pv = o_valid;
            ph = o_valid && i_ready;
        end
    end

    task automatic send(input logic [0:255] key, input logic k256, input logic newi,
                        input logic [SB_W-1:0] sb, input exp_t e);
        bit got;
        exp_q.push_back(e);
        i_cipher_key = key; i_key_256 = k256; i_new_instance = newi; i_sideband = sb;
        i_valid = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (o_ready) got = 1'b1;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        if (!got) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(posedge clk);
        if (exp_q.size() != 0) chk("drain_timeout", 128'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [SB_W-1:0] s;
        key128 = {K128, 128'hdeadbeef_cafef00d_01234567_89abcdef};
        key256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_cipher_key = '0;
        i_key_256 = 1'b0; i_new_instance = 1'b0; i_sideband = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 128'(o_valid), 0);
        chk("rst_ready", 128'(o_ready), 1);
        chk("rst_sched", 128'(|o_key_schedule), 0);
        chk("rst_sb", 128'(|o_sideband), 0);
        chk("rst_nr", 128'(o_num_rounds), 0);
        chk("rst_new", 128'(o_new_instance), 0);
        chk("rst_hit", 128'(o_cache_hit), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        i_ready = 1'b1;

        // AES-128 new instance: full expansion
        s = mk_sb(1);
        send(key128, 1'b0, 1'b1, s, mk_exp(s, 1'b0, 1'b1, 4'd10, 11, K128, RK1A, RK10A));
        drain();

        // Three cached beats, back to back
        for (int k = 0; k < 3; k++) begin
            s = mk_sb(10 + k);
            send(key128, 1'b0, 1'b0, s, mk_exp(s, 1'b1, 1'b0, 4'd10, 1, K128, RK1A, RK10A));
        end
        drain();

        // Stall in HOLD, then release together with a new hit beat
        i_ready = 1'b0;
        s = mk_sb(20);
        send(key128, 1'b0, 1'b0, s, mk_exp(s, 1'b1, 1'b0, 4'd10, 1, K128, RK1A, RK10A));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_valid", 128'(o_valid), 1);
            chk("hold_ready", 128'(o_ready), 0);
            chk("hold_sb", o_sideband[127:0], s[127:0]);
            chk("hold_rk10", rk(10), RK10A);
            chk("hold_hit", 128'(o_cache_hit), 1);
        end
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        s = mk_sb(21);
        send(key128, 1'b0, 1'b0, s, mk_exp(s, 1'b1, 1'b0, 4'd10, 1, K128, RK1A, RK10A));
        drain();

        // Reset during the 5th expansion cycle aborts and drops the cache
        s = mk_sb(30);
        send(key128, 1'b0, 1'b1, s, mk_exp(s, 1'b0, 1'b1, 4'd10, 11, K128, RK1A, RK10A));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("exp_ready", 128'(o_ready), 0);
            chk("exp_valid", 128'(o_valid), 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        #1;
        chk("abort_valid", 128'(o_valid), 0);
        chk("abort_sched", 128'(|o_key_schedule), 0);
        chk("abort_sb", 128'(|o_sideband), 0);
        chk("abort_nr", 128'(o_num_rounds), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        s = mk_sb(31);
        send(key128, 1'b0, 1'b0, s, mk_exp(s, 1'b0, 1'b0, 4'd10, 11, K128, RK1A, RK10A));
        drain();

        // Mode change without new_instance is a miss; then AES-256 hit
        s = mk_sb(40);
        send(key256, 1'b1, 1'b0, s, mk_exp(s, 1'b0, 1'b0, 4'd14, 14, key256[0:127], key256[128:255], RK14B));
        drain();
        s = mk_sb(41);
        send(key256, 1'b1, 1'b0, s, mk_exp(s, 1'b1, 1'b0, 4'd14, 1, key256[0:127], key256[128:255], RK14B));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
